// File: rtl/telemetry_arbiter_if.sv
// Requester and UART-side signal bundle for telemetry_arbiter.
// master drives requests and the FIFO flag; slave is the arbiter.
interface telemetry_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ*32-1:0] i_data;
  logic                  i_uart_full;
  logic [NUM_REQ-1:0]    o_ack;
  logic                  o_uart_wr;
  logic [7:0]            o_uart_data;
  logic                  o_busy;
  logic [1:0]            o_grant_id;
  logic [NUM_REQ-1:0]    o_overrun;

  modport master (
    output i_req, i_data, i_uart_full,
    input  o_ack, o_uart_wr, o_uart_data,
    input  o_busy, o_grant_id, o_overrun
  );

  modport slave (
    input  i_req, i_data, i_uart_full,
    output o_ack, o_uart_wr, o_uart_data,
    output o_busy, o_grant_id, o_overrun
  );
endinterface

// File: rtl/telemetry_arbiter.sv
// Round-robin arbiter framing 32-bit telemetry records onto one UART.
// Frame: header, four data bytes LSB first, XOR checksum.
module telemetry_arbiter #(
  parameter int         NUM_REQ  = 3,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  telemetry_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, HDR, D0, D1, D2, D3, CHK
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   pend_q, pend_d;
  logic [NUM_REQ-1:0]   ovr_q, ovr_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           gid_q, gid_d;
  logic [31:0]          sh_q, sh_d;
  logic [7:0]           csum_q, csum_d;

  logic                 grant_vld;
  logic                 grant;
  logic [1:0]           grant_idx;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [31:0]          rec;
  logic                 wr;
  logic [7:0]           byte_out;
  logic [7:0]           hdr;

  assign hdr   = HDR_BASE | {6'b0, gid_q};
  assign grant = (state_q == IDLE) && grant_vld;

  // First pending index at or after last_q+1, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_vld && pend_q[k] &&
            k == (int'(last_q) + i) % NUM_REQ) begin
          grant_vld = 1'b1;
          grant_idx = 2'(k);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    rec      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == 2'(k)) begin
        grant_oh[k] = grant;
        rec         = bus.i_data[32*k +: 32];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_vld) state_d = HDR;
      HDR:     if (wr) state_d = D0;
      D0:      if (wr) state_d = D1;
      D1:      if (wr) state_d = D2;
      D2:      if (wr) state_d = D3;
      D3:      if (wr) state_d = CHK;
      CHK:     if (wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr       = (state_q != IDLE) && !bus.i_uart_full;
    byte_out = 8'h00;
    unique case (state_q)
      HDR:            byte_out = hdr;
      D0, D1, D2, D3: byte_out = sh_q[7:0];
      CHK:            byte_out = csum_q;
      default:        byte_out = 8'h00;
    endcase
  end

  // A request on its own grant cycle re-arms pending, no overrun.
  always_comb begin
    pend_d = (pend_q & ~grant_oh) | bus.i_req;
    ovr_d  = ovr_q | (pend_q & ~grant_oh & bus.i_req);
    last_d = last_q;
    gid_d  = gid_q;
    sh_d   = sh_q;
    csum_d = csum_q;
    if (grant) begin
      last_d = grant_idx;
      gid_d  = grant_idx;
      sh_d   = rec;
      csum_d = '0;
    end else if (wr) begin
      csum_d = csum_q ^ byte_out;
      if (state_q != HDR) sh_d = {8'h00, sh_q[31:8]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
      last_q <= 2'(NUM_REQ - 1);
      gid_q  <= '0;
      sh_q   <= '0;
      csum_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      last_q <= last_d;
      gid_q  <= gid_d;
      sh_q   <= sh_d;
      csum_q <= csum_d;
    end
  end

  assign bus.o_ack       = grant_oh;
  assign bus.o_uart_wr   = wr;
  assign bus.o_uart_data = byte_out;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_grant_id  = gid_q;
  assign bus.o_overrun   = ovr_q;

endmodule

// File: tb/tb_telemetry_arbiter.sv
// Self-checking bench for telemetry_arbiter: frame-queue model,
// directed scenarios and randomized traffic with backpressure.
module tb_telemetry_arbiter;
  localparam int N = 3;

  localparam logic [7:0] E_ONE [6] =
    '{8'hA0, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA8};
  localparam logic [7:0] E_RR [5] =
    '{8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA2};
  localparam logic [7:0] E_RST [6] =
    '{8'hA0, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h69};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  telemetry_arbiter_if #(.NUM_REQ(N)) bus();

  telemetry_arbiter #(.NUM_REQ(N), .HDR_BASE(8'hA0)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] wlog[$];
  int ack_cnt[N];

  logic [7:0] fq[$];
  bit m_pend[N];
  bit m_ovr[N];
  int m_last = N - 1;
  int m_gid = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is a queue of six bytes; idle means empty.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_ovr;
    logic e_wr;
    logic [7:0] e_data;
    logic [31:0] d;
    e_ack = '0;
    e_wr = 1'b0;
    e_data = 8'h00;
    g = -1;
    for (int k = 0; k < N; k++) e_ovr[k] = m_ovr[k];
    if (!rst_n) begin
      fq.delete();
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 1'b0;
        m_ovr[k] = 1'b0;
      end
      m_last = N - 1;
      m_gid = 0;
      chk("rst_wr", 32'(bus.o_uart_wr), 0);
      chk("rst_busy", 32'(bus.o_busy), 0);
      chk("rst_ack", 32'(bus.o_ack), 0);
      chk("rst_ovr", 32'(bus.o_overrun), 0);
      chk("rst_gid", 32'(bus.o_grant_id), 0);
    end else begin
      if (fq.size() == 0) begin
        for (int i = 1; i <= N; i++)
          if (g < 0 && m_pend[(m_last + i) % N]) g = (m_last + i) % N;
        if (g >= 0) e_ack[g] = 1'b1;
      end else begin
        e_wr = !bus.i_uart_full;
        e_data = fq[0];
      end
      chk("ack", 32'(bus.o_ack), 32'(e_ack));
      chk("busy", 32'(bus.o_busy), 32'(fq.size() != 0));
      chk("wr", 32'(bus.o_uart_wr), 32'(e_wr));
      if (e_wr) chk("data", 32'(bus.o_uart_data), 32'(e_data));
      chk("gid", 32'(bus.o_grant_id), 32'(m_gid));
      chk("ovr", 32'(bus.o_overrun), 32'(e_ovr));
      if (bus.o_uart_wr) wlog.push_back(bus.o_uart_data);
      for (int k = 0; k < N; k++) if (bus.o_ack[k]) ack_cnt[k]++;
      for (int k = 0; k < N; k++) begin
        if (m_pend[k] && bus.i_req[k] && k != g) m_ovr[k] = 1'b1;
        m_pend[k] = (m_pend[k] && k != g) || bus.i_req[k];
      end
      if (g >= 0) begin
        d = bus.i_data[32*g +: 32];
        fq.push_back(8'hA0 | 8'(g));
        for (int b = 0; b < 4; b++) fq.push_back(d[8*b +: 8]);
        fq.push_back(8'hA0 ^ 8'(g) ^ d[7:0] ^ d[15:8]
                     ^ d[23:16] ^ d[31:24]);
        m_last = g;
        m_gid = g;
      end else if (e_wr) begin
        void'(fq.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int k, input logic [31:0] d);
    bus.i_data[32*k +: 32] = d;
    bus.i_req[k] = 1'b1;
    cyc(1);
    bus.i_req[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    wlog.delete();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
  endtask

  task automatic wait_byte(input logic [7:0] b, input string name);
    int n;
    n = 0;
    while (!(bus.o_busy && bus.o_uart_data == b) && n < 40) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(n < 40), 1);
  endtask

  initial begin
    int n56;
    bus.i_req = '0;
    bus.i_data = '0;
    bus.i_uart_full = 1'b0;
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("init_gid", 32'(bus.o_grant_id), 0);
    chk("init_busy", 32'(bus.o_busy), 0);

    // single record
    wlog.delete();
    pulse(0, 32'h12345678);
    cyc(10);
    chk("one_len", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("one_byte", 32'(wlog[i]), 32'(E_ONE[i]));
    chk("one_ack", ack_cnt[0], 1);
    chk("one_idle", 32'(bus.o_busy), 0);

    // round robin
    do_reset();
    bus.i_data = {32'h33333333, 32'h22222222, 32'h11111111};
    bus.i_req = 3'b111;
    cyc(1);
    bus.i_req = '0;
    cyc(17);
    bus.i_req = 3'b101;
    cyc(1);
    bus.i_req = '0;
    cyc(40);
    chk("rr_len", wlog.size(), 30);
    for (int i = 0; i < 5 && 6*i < wlog.size(); i++)
      chk("rr_hdr", 32'(wlog[6*i]), 32'(E_RR[i]));

    // backpressure on D1
    do_reset();
    pulse(0, 32'h12345678);
    wait_byte(8'h56, "bp_reach_d1");
    bus.i_uart_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wr", 32'(bus.o_uart_wr), 0);
      chk("bp_data", 32'(bus.o_uart_data), 32'h56);
      @(posedge clk);
      #1;
    end
    bus.i_uart_full = 1'b0;
    cyc(12);
    n56 = 0;
    foreach (wlog[i]) if (wlog[i] == 8'h56) n56++;
    chk("bp_one56", n56, 1);
    chk("bp_len", wlog.size(), 6);

    // overrun
    do_reset();
    pulse(0, 32'h01020304);
    cyc(1);
    pulse(1, 32'hAAAA0001);
    cyc(1);
    pulse(1, 32'hBBBB0002);
    cyc(3);
    chk("ovr_set", 32'(bus.o_overrun), 32'b010);
    cyc(20);
    chk("ovr_sticky", 32'(bus.o_overrun), 32'b010);
    chk("ovr_len", wlog.size(), 12);
    chk("ovr_acks", ack_cnt[1], 1);
    if (wlog.size() >= 12) begin
      chk("ovr_hdr", 32'(wlog[6]), 32'hA1);
      chk("ovr_b0", 32'(wlog[7]), 32'h02);
      chk("ovr_b2", 32'(wlog[9]), 32'hBB);
    end

    // re-request on own grant cycle
    do_reset();
    bus.i_data[64 +: 32] = 32'h11223344;
    bus.i_req[2] = 1'b1;
    cyc(1);
    chk("rg_ack", 32'(bus.o_ack), 32'b100);
    cyc(1);
    bus.i_req[2] = 1'b0;
    cyc(20);
    chk("rg_ovr", 32'(bus.o_overrun), 0);
    chk("rg_acks", ack_cnt[2], 2);
    chk("rg_len", wlog.size(), 12);
    if (wlog.size() >= 12) begin
      chk("rg_hdr0", 32'(wlog[0]), 32'hA2);
      chk("rg_hdr1", 32'(wlog[6]), 32'hA2);
    end

    // reset during D2
    do_reset();
    pulse(0, 32'h12345678);
    wait_byte(8'h34, "mr_reach_d2");
    rst_n = 1'b0;
    #1;
    chk("mr_wr", 32'(bus.o_uart_wr), 0);
    chk("mr_busy", 32'(bus.o_busy), 0);
    cyc(2);
    rst_n = 1'b1;
    wlog.delete();
    pulse(0, 32'hCAFEF00D);
    cyc(12);
    chk("mr_len", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk("mr_byte", 32'(wlog[i]), 32'(E_RST[i]));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(699) == 0) begin
        bus.i_req = '0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(5) == 0) begin
          bus.i_data[32*k +: 32] = $urandom;
          bus.i_req[k] = 1'b1;
        end else begin
          bus.i_req[k] = 1'b0;
        end
      end
      bus.i_uart_full = ($urandom_range(3) == 0);
      cyc(1);
    end
    bus.i_req = '0;
    bus.i_uart_full = 1'b0;
    cyc(40);
    chk("end_idle", 32'(bus.o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/telemetry_arbiter.md
# telemetry_arbiter

Round-robin arbiter that shares the single 8-bit UART transmit path (`uart_top`) between up to four 32-bit telemetry requesters, e.g. {velocity, setpoint}, encoder position and PID probe. It latches each requester's record and serialises it as a fixed 6-byte frame: header, four data bytes LSB first, then an XOR checksum. It obeys the UART FIFO full flag, so no byte is ever dropped or duplicated. It sits between the sampling/control logic and `uart_top`, and replaces ad-hoc per-source byte-splitting FSMs.

## Interface
- `NUM_REQ`, 3, number of requesters, legal range 1..4.
- `HDR_BASE`, 8'hA0, header byte base; header = `HDR_BASE | {6'b0, grant index}`.

- `i_clk`  in  1  system clock (12 MHz PLL output); all logic on rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_req`  in  NUM_REQ  per-requester record-ready; sampled every cycle; a pulse or a level are both legal.
- `i_data`  in  NUM_REQ*32  flattened records; requester k occupies bits [32k+31:32k]; must be stable from the req cycle until `o_ack[k]`.
- `i_uart_full`  in  1  UART TX FIFO full; no write is issued while high.
- `o_ack`  out  NUM_REQ  one-cycle pulse when requester k's record is latched.
- `o_uart_wr`  out  1  byte write strobe to `uart_top`.
- `o_uart_data`  out  8  byte to write; valid whenever `o_uart_wr` = 1.
- `o_busy`  out  1  high in every state except IDLE.
- `o_grant_id`  out  2  index of the record being sent; holds the last value while idle.
- `o_overrun`  out  NUM_REQ  sticky; set when a requester re-requests while its earlier request is still pending.

## Operation
- `pending[k]` is set on any cycle with `i_req[k]` = 1. It is cleared on the grant cycle of k.
- If `i_req[k]` = 1 on k's own grant cycle, `pending[k]` stays set. This is a new request, not an overrun.
- If `i_req[k]` = 1 while `pending[k]` is already set and k is not being granted, `o_overrun[k]` is set. Only one record is sent for those requests, and the latest `i_data` is the one latched at grant.
- `o_overrun` clears only on reset.
- The FSM states are IDLE, HDR, D0, D1, D2, D3 and CHK.
- **IDLE:** if any `pending` bit is set, grant the first pending index searching upward from `last_grant+1` and wrapping modulo NUM_REQ. On the grant cycle:
  - latch `i_data[k]` into a 32-bit shift register;
  - set `o_grant_id` and `last_grant` to k;
  - pulse `o_ack[k]`;
  - go to HDR.
- **HDR..CHK:** `o_uart_wr` = (state != IDLE) && !`i_uart_full`, combinational. The state advances only on a cycle where `o_uart_wr` = 1.
  - While full, the state and the presented byte are held.
- Byte order: HDR = header; D0 = data[7:0]; D1 = [15:8]; D2 = [23:16]; D3 = [31:24]; CHK = XOR of header and D0..D3.
- The checksum is accumulated in an 8-bit register as each byte is written.
- After the CHK write the FSM goes to IDLE. There is no preemption: a frame, once granted, completes.
- Reset (any time, including mid-frame):
  - state = IDLE; `pending`, `o_ack`, `o_overrun`, `o_busy` and `o_uart_wr` = 0;
  - `o_grant_id` = 0; `last_grant` = NUM_REQ-1, so requester 0 has first priority;
  - shift register and checksum = 0.
  - A partially sent frame is abandoned, not resumed.

## Timing
- Latency from request to grant: `i_req` at cycle t sets `pending` at t+1. The earliest grant (`o_ack`) is at t+1 if idle. The header write is at the earliest t+2.
- A frame takes 6 write cycles plus full-stall cycles. Minimum spacing between two grants is 7 cycles (1 IDLE + 6 writes).
- `o_ack` is exactly 1 cycle wide, with at most one bit high per cycle.
- `o_uart_wr` and `o_uart_data` react combinationally to `i_uart_full` in the same cycle. Hence `uart_top` must sample full and wr on the same edge.
- Reset deassertion is synchronous to `i_clk` externally; the earliest grant is on the first edge after release on which `pending` is set.

## Test plan
- **Single record:** req0 pulsed with data 0x12345678, full = 0 → `o_ack[0]` pulses once, then 6 consecutive writes A0, 78, 56, 34, 12, A8; `o_busy` falls after the A8 write.
- **Round robin:** req0, req1 and req2 pulsed in the same cycle, then req0 and req2 pulsed during the third frame → headers in order A0, A1, A2, A0, A2.
- **Backpressure:** full held high for 10 cycles starting while D1 is presented → `o_uart_wr` = 0 for those 10 cycles, byte 0x56 held on `o_uart_data`, exactly one 0x56 write after release, and the frame total is still 6 writes.
- **Overrun:** req1 pulsed twice while frame 0 is being sent → `o_overrun[1]` = 1 and stays 1; exactly one A1 frame carries the `i_data` present at grant.
- **Re-request on grant cycle:** req2 high on its own ack cycle → a second A2 frame follows and `o_overrun[2]` stays 0.
- **Reset mid-frame:** `i_rst_n` low during D2 → `o_uart_wr`, `o_busy` and `pending` go to 0 immediately; after release with req0 pulsed, the next bytes are a complete new frame starting A0.
